// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, ALU ops, opcodes and mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [4:0] {
        FETCH,
        FETCH_WAIT,
        DECODE,
        EXEC_R,
        EXEC_I,
        EXEC_LUI,
        WB_ALU,
        ADDR,
        MEM_WRITE,
        MEM_READ,
        MEM_WAIT,
        MEM_WB,
        BR_CMP,
        BR_UPD,
        JAL_LINK,
        JAL_WB,
        JALR_LINK,
        JALR_JUMP,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_t;

    // Major opcodes; anything not listed here (SYSTEM included) stops the core
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC   = 2'd0;
    localparam logic [1:0] SRCA_A    = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    // ALU operand B select
    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // PC source select
    localparam logic PCSRC_ALU_RES = 1'b0;
    localparam logic PCSRC_ALU_OUT = 1'b1;

    // Register writeback source select
    localparam logic [1:0] MTR_ALU_OUT = 2'd0;
    localparam logic [1:0] MTR_MEM     = 2'd1;
    localparam logic [1:0] MTR_PC      = 2'd2;

    // Load/store width splice codes
    localparam logic [1:0] SPLICE_D = 2'd0;
    localparam logic [1:0] SPLICE_W = 2'd1;
    localparam logic [1:0] SPLICE_H = 2'd2;
    localparam logic [1:0] SPLICE_B = 2'd3;

    // Width code from funct3; the unsigned-load bit (funct3[2]) does not change width
    function automatic logic [1:0] splice_sel(input logic [2:0] funct3);
        logic [1:0] sel;
        case (funct3[1:0])
            2'b11:   sel = SPLICE_D;
            2'b10:   sel = SPLICE_W;
            2'b01:   sel = SPLICE_H;
            default: sel = SPLICE_B;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R-type and OP-IMM instructions from opcode/funct3/funct7[5].
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_op
);

    // funct7[5] picks SUB only for register-register ops; for immediates it is an imm bit
    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_R || opcode == OP_IMM) begin
            case (funct3)
                3'b000:  alu_op = (opcode == OP_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                3'b111:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM for the RV64 subset datapath; decodes IR and compare flags into datapath controls.
// Latency: 5 cycles per instruction, 7 for loads; control outputs are Moore-decoded from state and IR.
// Backpressure: none; memories have fixed latency, and HALT holds until reset.
module control_fsm
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        alu_equal,
    input  logic        alu_less,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        PCWriteState,
    output logic        PCSource,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        LoadAOut,
    output logic        RegWrite,
    output logic        LoadRegA,
    output logic        LoadRegB,
    output logic [1:0]  MemToReg,
    output logic [1:0]  LoadSplice,
    output logic [1:0]  StoreSplice,
    output logic        DMemOp,
    output logic        LoadMDR,
    output logic        IMemRead,
    output logic        IRWrite,
    output logic        halt
);

    state_t     state;
    logic       taken_q;
    logic       inc;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [3:0] dec_alu_op;
    logic       unused_ir_bits;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_b5 = instruction[30];

    // Register numbers and immediates are consumed by the datapath, not here
    assign unused_ir_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (dec_alu_op)
    );

    // Sequencing: state advance, opcode dispatch and branch-outcome capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            taken_q <= 1'b0;
        end else begin
            unique case (state)
                FETCH:      state <= FETCH_WAIT;
                FETCH_WAIT: state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:               state <= EXEC_R;
                        OP_IMM:             state <= EXEC_I;
                        OP_LUI:             state <= EXEC_LUI;
                        OP_LOAD, OP_STORE:  state <= ADDR;
                        OP_BRANCH:          state <= BR_CMP;
                        OP_JAL:             state <= JAL_LINK;
                        OP_JALR:            state <= JALR_LINK;
                        default:            state <= HALT;
                    endcase
                end
                EXEC_R, EXEC_I, EXEC_LUI: state <= WB_ALU;
                WB_ALU:     state <= FETCH;
                ADDR:       state <= (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                MEM_WRITE:  state <= FETCH;
                MEM_READ:   state <= MEM_WAIT;
                MEM_WAIT:   state <= MEM_WB;
                MEM_WB:     state <= FETCH;
                BR_CMP: begin
                    state <= BR_UPD;
                    case (funct3)
                        F3_BEQ:  taken_q <= alu_equal;
                        F3_BNE:  taken_q <= ~alu_equal;
                        F3_BLT:  taken_q <= alu_less;
                        F3_BGE:  taken_q <= ~alu_less;
                        default: state   <= HALT;
                    endcase
                end
                BR_UPD:     state <= FETCH;
                JAL_LINK:   state <= JAL_WB;
                JAL_WB:     state <= FETCH;
                JALR_LINK:  state <= JALR_JUMP;
                JALR_JUMP:  state <= FETCH;
                HALT:       state <= HALT;
                default:    state <= HALT;
            endcase
        end
    end

    // Moore control decode; everything is forced low while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU_RES;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_ADD;
        LoadAOut    = 1'b0;
        RegWrite    = 1'b0;
        LoadRegA    = 1'b0;
        LoadRegB    = 1'b0;
        MemToReg    = MTR_ALU_OUT;
        LoadSplice  = SPLICE_D;
        StoreSplice = SPLICE_D;
        DMemOp      = 1'b0;
        LoadMDR     = 1'b0;
        IMemRead    = 1'b0;
        IRWrite     = 1'b0;
        halt        = 1'b0;
        inc         = 1'b0;
        if (!reset) begin
            unique case (state)
                FETCH:      IMemRead = 1'b1;
                FETCH_WAIT: IRWrite  = 1'b1;
                DECODE: begin
                    // Operand latch plus speculative branch/JAL target into alu_out
                    LoadRegA = 1'b1;
                    LoadRegB = 1'b1;
                    ALUSrcA  = SRCA_PC;
                    ALUSrcB  = SRCB_IMM;
                    ALUOp    = ALU_ADD;
                    LoadAOut = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA  = SRCA_A;
                    ALUSrcB  = SRCB_B;
                    ALUOp    = dec_alu_op;
                    LoadAOut = 1'b1;
                end
                EXEC_I: begin
                    ALUSrcA  = SRCA_A;
                    ALUSrcB  = SRCB_IMM;
                    ALUOp    = dec_alu_op;
                    LoadAOut = 1'b1;
                end
                EXEC_LUI: begin
                    ALUSrcA  = SRCA_ZERO;
                    ALUSrcB  = SRCB_IMM;
                    ALUOp    = ALU_ADD;
                    LoadAOut = 1'b1;
                end
                WB_ALU: begin
                    RegWrite = 1'b1;
                    MemToReg = MTR_ALU_OUT;
                    inc      = 1'b1;
                end
                ADDR: begin
                    ALUSrcA  = SRCA_A;
                    ALUSrcB  = SRCB_IMM;
                    ALUOp    = ALU_ADD;
                    LoadAOut = 1'b1;
                end
                MEM_WRITE: begin
                    DMemOp      = 1'b1;
                    StoreSplice = splice_sel(funct3);
                    inc         = 1'b1;
                end
                MEM_READ: begin
                    // Data memory read in flight; nothing to drive
                end
                MEM_WAIT:   LoadMDR = 1'b1;
                MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemToReg   = MTR_MEM;
                    LoadSplice = splice_sel(funct3);
                    inc        = 1'b1;
                end
                BR_CMP: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_B;
                    ALUOp   = ALU_SUB;
                end
                BR_UPD: begin
                    // Taken: PC <= target already held in alu_out since DECODE
                    if (taken_q) begin
                        PCWriteCond = 1'b1;
                        PCSource    = PCSRC_ALU_OUT;
                    end else begin
                        inc = 1'b1;
                    end
                end
                JAL_LINK: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_ALU_OUT;
                    ALUSrcA  = SRCA_PC;
                    ALUSrcB  = SRCB_FOUR;
                    ALUOp    = ALU_ADD;
                    LoadAOut = 1'b1;
                end
                JAL_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = MTR_ALU_OUT;
                end
                JALR_LINK: begin
                    ALUSrcA  = SRCA_PC;
                    ALUSrcB  = SRCB_FOUR;
                    ALUOp    = ALU_ADD;
                    LoadAOut = 1'b1;
                end
                JALR_JUMP: begin
                    // Target from A latched in DECODE, so rd==rs1 cannot corrupt it
                    ALUSrcA  = SRCA_A;
                    ALUSrcB  = SRCB_IMM;
                    ALUOp    = ALU_ADD;
                    PCSource = PCSRC_ALU_RES;
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    MemToReg = MTR_ALU_OUT;
                end
                HALT:       halt = 1'b1;
                default:    halt = 1'b1;
            endcase
            if (inc) begin
                ALUSrcA  = SRCA_PC;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                PCSource = PCSRC_ALU_RES;
                PCWrite  = 1'b1;
            end
        end
    end

    // PC write enable seen by the datapath: unconditional or resolved-taken branch
    assign PCWriteState = PCWrite | (PCWriteCond & taken_q);

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed instruction sequences plus randomized instruction stream.
// Latency: expects 5 cycles per instruction, 7 per load, sticky HALT.
// Backpressure: none.
module tb_control_fsm;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        alu_equal = 1'b0;
    logic        alu_less = 1'b0;

    logic        PCWrite, PCWriteCond, PCWriteState, PCSource;
    logic [1:0]  ALUSrcA, ALUSrcB;
    logic [3:0]  ALUOp;
    logic        LoadAOut, RegWrite, LoadRegA, LoadRegB;
    logic [1:0]  MemToReg, LoadSplice, StoreSplice;
    logic        DMemOp, LoadMDR, IMemRead, IRWrite, halt;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       PCWriteState;
        logic       PCSource;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [3:0] ALUOp;
        logic       LoadAOut;
        logic       RegWrite;
        logic       LoadRegA;
        logic       LoadRegB;
        logic [1:0] MemToReg;
        logic [1:0] LoadSplice;
        logic [1:0] StoreSplice;
        logic       DMemOp;
        logic       LoadMDR;
        logic       IMemRead;
        logic       IRWrite;
        logic       halt;
    } ctl_t;

    ctl_t got;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .alu_equal    (alu_equal),
        .alu_less     (alu_less),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .PCWriteState (PCWriteState),
        .PCSource     (PCSource),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .LoadAOut     (LoadAOut),
        .RegWrite     (RegWrite),
        .LoadRegA     (LoadRegA),
        .LoadRegB     (LoadRegB),
        .MemToReg     (MemToReg),
        .LoadSplice   (LoadSplice),
        .StoreSplice  (StoreSplice),
        .DMemOp       (DMemOp),
        .LoadMDR      (LoadMDR),
        .IMemRead     (IMemRead),
        .IRWrite      (IRWrite),
        .halt         (halt)
    );

    assign got = {PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                  LoadAOut, RegWrite, LoadRegA, LoadRegB, MemToReg, LoadSplice, StoreSplice,
                  DMemOp, LoadMDR, IMemRead, IRWrite, halt};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ALU operation named by the instruction mnemonic
    function automatic logic [3:0] ref_alu_op(input logic [31:0] ins);
        logic       is_r = (ins[6:0] == 7'h33);
        logic [3:0] op;
        case (ins[14:12])
            3'd0:    op = (is_r && ins[31:25] == 7'h20) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd4:    op = ALU_XOR;
            3'd5:    op = (ins[31:25] == 7'h20) ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // d/w/h/b from ld/lw/lh/lb (sd/sw/sh/sb)
    function automatic logic [1:0] ref_splice(input logic [2:0] f3);
        logic [1:0] s;
        case (f3)
            3'b011:  s = 2'd0;
            3'b010:  s = 2'd1;
            3'b001:  s = 2'd2;
            default: s = 2'd3;
        endcase
        return s;
    endfunction

    function automatic bit valid_branch(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic bit branch_outcome(input logic [2:0] f3, input logic eq, input logic lt);
        bit t;
        case (f3)
            3'd0:    t = eq;
            3'd1:    t = !eq;
            3'd4:    t = lt;
            default: t = !lt;
        endcase
        return t;
    endfunction

    // Expected control word in cycle k of an instruction (k=0 is its fetch cycle)
    function automatic ctl_t model(input logic [31:0] ins, input int k, input bit taken);
        ctl_t       c = '0;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        bit         inc = 1'b0;
        if (k == 0) c.IMemRead = 1'b1;
        else if (k == 1) c.IRWrite = 1'b1;
        else if (k == 2) begin
            c.LoadRegA = 1'b1; c.LoadRegB = 1'b1; c.ALUSrcB = 2'd2; c.LoadAOut = 1'b1;
        end else begin
            case (op)
                7'h33, 7'h13, 7'h37: begin
                    if (k == 3) begin
                        c.ALUSrcA  = (op == 7'h37) ? 2'd2 : 2'd1;
                        c.ALUSrcB  = (op == 7'h33) ? 2'd0 : 2'd2;
                        c.ALUOp    = (op == 7'h37) ? ALU_ADD : ref_alu_op(ins);
                        c.LoadAOut = 1'b1;
                    end else begin
                        c.RegWrite = 1'b1; inc = 1'b1;
                    end
                end
                7'h03, 7'h23: begin
                    if (k == 3) begin
                        c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd2; c.LoadAOut = 1'b1;
                    end else if (op == 7'h23) begin
                        c.DMemOp = 1'b1; c.StoreSplice = ref_splice(f3); inc = 1'b1;
                    end else if (k == 5) c.LoadMDR = 1'b1;
                    else if (k == 6) begin
                        c.RegWrite = 1'b1; c.MemToReg = 2'd1; c.LoadSplice = ref_splice(f3); inc = 1'b1;
                    end
                end
                7'h63: begin
                    if (k == 3) begin
                        c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd0; c.ALUOp = ALU_SUB;
                    end else if (!valid_branch(f3)) c.halt = 1'b1;
                    else if (taken) begin
                        c.PCWriteCond = 1'b1; c.PCSource = 1'b1; c.PCWriteState = 1'b1;
                    end else inc = 1'b1;
                end
                7'h6F: begin
                    if (k == 3) begin
                        c.PCWrite = 1'b1; c.PCSource = 1'b1; c.PCWriteState = 1'b1;
                        c.ALUSrcB = 2'd1; c.LoadAOut = 1'b1;
                    end else c.RegWrite = 1'b1;
                end
                7'h67: begin
                    if (k == 3) begin
                        c.ALUSrcB = 2'd1; c.LoadAOut = 1'b1;
                    end else begin
                        c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd2; c.PCWrite = 1'b1;
                        c.PCWriteState = 1'b1; c.RegWrite = 1'b1;
                    end
                end
                default: c.halt = 1'b1;
            endcase
        end
        if (inc) begin
            c.ALUSrcA = 2'd0; c.ALUSrcB = 2'd1; c.ALUOp = ALU_ADD; c.PCSource = 1'b0;
            c.PCWrite = 1'b1; c.PCWriteState = 1'b1;
        end
        return c;
    endfunction

    // Cycles to observe: full instruction, or a few HALT cycles for stopping instructions
    function automatic int cycles_for(input logic [31:0] ins, input int halt_cycles);
        int n;
        case (ins[6:0])
            7'h33, 7'h13, 7'h37, 7'h23, 7'h6F, 7'h67: n = 5;
            7'h03:   n = 7;
            7'h63:   n = valid_branch(ins[14:12]) ? 5 : 4 + halt_cycles;
            default: n = 3 + halt_cycles;
        endcase
        return n;
    endfunction

    function automatic bit stops(input logic [31:0] ins);
        case (ins[6:0])
            7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h6F, 7'h67: return 1'b0;
            7'h63:   return !valid_branch(ins[14:12]);
            default: return 1'b1;
        endcase
    endfunction

    // Entered and left at #1 after a rising edge; compares every cycle on the falling edge
    task automatic run_instr(input logic [31:0] ins, input int ncyc, input string name,
                             input bit force_eq, input logic eq_val);
        bit taken = 1'b0;
        instruction = ins;
        for (int k = 0; k < ncyc; k++) begin
            alu_equal = force_eq ? eq_val : 1'($urandom_range(1, 0));
            alu_less  = 1'($urandom_range(1, 0));
            if (k == 3) taken = branch_outcome(ins[14:12], alu_equal, alu_less);
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, k), 32'(got), 32'(model(ins, k, taken)));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #1;
        check({name, " rst_zero"}, 32'(got), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [2:0]  f3;
        logic [6:0]  op;
        logic [2:0]  alu_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0]  br_ok  [4] = '{3'd0, 3'd1, 3'd4, 3'd5};
        logic [2:0]  br_bad [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
        case ($urandom_range(9, 0))
            0, 9: begin
                f3 = alu_f3[$urandom_range(6, 0)];
                r[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
                r[14:12] = f3; r[6:0] = 7'h33;
            end
            1: begin
                f3 = alu_f3[$urandom_range(6, 0)];
                if (f3 == 3'd1) r[31:25] = 7'h00;
                if (f3 == 3'd5) r[31:25] = r[1] ? 7'h20 : 7'h00;
                r[14:12] = f3; r[6:0] = 7'h13;
            end
            2: r[6:0] = 7'h37;
            3: begin r[14:12] = 3'($urandom_range(3, 0)); r[6:0] = 7'h03; end
            4: begin r[14:12] = 3'($urandom_range(3, 0)); r[6:0] = 7'h23; end
            5: begin
                r[14:12] = ($urandom_range(7, 0) == 0) ? br_bad[$urandom_range(3, 0)]
                                                       : br_ok[$urandom_range(3, 0)];
                r[6:0] = 7'h63;
            end
            6: r[6:0] = 7'h6F;
            7: begin r[14:12] = 3'd0; r[6:0] = 7'h67; end
            default: begin
                op = 7'($urandom);
                while (op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h03 ||
                       op == 7'h23 || op == 7'h63 || op == 7'h6F || op == 7'h67)
                    op = 7'($urandom);
                r[6:0] = op;
            end
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t        fetch_only;
        logic [31:0] ins;
        fetch_only = '0;
        fetch_only.IMemRead = 1'b1;

        // Reset held three cycles: outputs silent, then FETCH on the first free cycle
        #2;
        check("reset_hold", 32'(got), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("post_reset_fetch", 32'(got), 32'(fetch_only));
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;

        run_instr(32'h002081B3, 5, "add", 1'b0, 1'b0);
        run_instr(32'h0080B283, 7, "ld", 1'b0, 1'b0);
        run_instr(32'h00208463, 5, "beq_taken", 1'b1, 1'b1);
        run_instr(32'h00208463, 5, "beq_not", 1'b1, 1'b0);
        run_instr(32'h010000EF, 5, "jal", 1'b0, 1'b0);
        run_instr(32'h0020A423, 5, "sw", 1'b0, 1'b0);
        run_instr(32'h00008067, 5, "jalr", 1'b0, 1'b0);
        run_instr(32'h123452B7, 5, "lui", 1'b0, 1'b0);
        run_instr(32'h4020D1B3, 5, "sra", 1'b0, 1'b0);
        run_instr(32'h00100073, 23, "ebreak", 1'b0, 1'b0);
        pulse_reset("ebreak");

        // Reset pulse in the middle of ADDR abandons the load
        run_instr(32'h0080B283, 3, "ld_abort", 1'b0, 1'b0);
        #1;
        check("ld_abort in_addr", 32'(got), 32'(model(32'h0080B283, 3, 1'b0)));
        reset = 1'b1;
        #1;
        check("ld_abort rst_async", 32'(got), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(32'h002081B3, 5, "add_after_abort", 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ins = gen_instr();
            run_instr(ins, cycles_for(ins, 4), $sformatf("rand%0d_%h", i, ins), 1'b0, 1'b0);
            if (stops(ins)) pulse_reset($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
